// File: rtl/jogo_rodadas_unidade_controle.sv
// Round-based memory game control unit (Moore FSM).
// Each round N asks the player to repeat memory positions 0..N. The game ends
// on a mismatch, on completing the last round, or on a per-play timeout.
// Optional feature: define JOGO_TIMEOUT_EN to build the play timer and the
// fim_timeout end state; otherwise espera waits indefinitely and timeout = 0.
module jogo_rodadas_unidade_controle #(
  parameter int unsigned TIMEOUT_CICLOS = 5000,
  parameter int unsigned TIMER_W        = $clog2(TIMEOUT_CICLOS)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fim_endereco,
  input  logic       fim_rodada,
  output logic       zera_endereco,
  output logic       conta_endereco,
  output logic       zera_rodada,
  output logic       conta_rodada,
  output logic       zera_registro,
  output logic       registra,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic       pronto,
  output logic       vez_jogador,
  output logic [3:0] db_estado
);

  // Parameter sanity: the window needs at least two cycles and must fit the timer.
  if (TIMEOUT_CICLOS < 2) begin : g_timeout_invalido
    $error("TIMEOUT_CICLOS must be at least 2");
  end
  if ((64'(1) << TIMER_W) < 64'(TIMEOUT_CICLOS)) begin : g_timer_estreito
    $error("TIMER_W too narrow for TIMEOUT_CICLOS");
  end

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIA_RODADA  = 4'h2,
    ESPERA         = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMO        = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_ACERTO     = 4'hA,
`ifdef JOGO_TIMEOUT_EN
    FIM_TIMEOUT    = 4'hD,
`endif
    FIM_ERRO       = 4'hE
  } estado_t;

  estado_t estado;
  estado_t proximo_estado;

  // State register; reset returns to inicial immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= INICIAL;
    else       estado <= proximo_estado;
  end

`ifdef JOGO_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] LIMITE = TIMER_W'(TIMEOUT_CICLOS - 1);

  logic [TIMER_W-1:0] timer;
  logic               expirou;

  // Play timer: counts cycles spent in espera, cleared in every other state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 timer <= '0;
    else if (estado == ESPERA) timer <= timer + TIMER_W'(1);
    else                       timer <= '0;
  end

  assign expirou = (timer == LIMITE);
`endif

  // Next-state and Moore output decode from the registered state only.
  always_comb begin
    proximo_estado = INICIAL;
    zera_endereco  = 1'b0;
    conta_endereco = 1'b0;
    zera_rodada    = 1'b0;
    conta_rodada   = 1'b0;
    zera_registro  = 1'b0;
    registra       = 1'b0;
    acertou        = 1'b0;
    errou          = 1'b0;
    timeout        = 1'b0;
    pronto         = 1'b0;
    vez_jogador    = 1'b0;
    db_estado      = 4'hF;
    case (estado)
      INICIAL: begin
        db_estado      = 4'h0;
        zera_endereco  = 1'b1;
        zera_rodada    = 1'b1;
        zera_registro  = 1'b1;
        proximo_estado = iniciar ? PREPARACAO : INICIAL;
      end
      PREPARACAO: begin
        db_estado      = 4'h1;
        zera_endereco  = 1'b1;
        zera_rodada    = 1'b1;
        zera_registro  = 1'b1;
        proximo_estado = INICIA_RODADA;
      end
      INICIA_RODADA: begin
        db_estado      = 4'h2;
        zera_endereco  = 1'b1;
        proximo_estado = ESPERA;
      end
      ESPERA: begin
        db_estado      = 4'h3;
        vez_jogador    = 1'b1;
        proximo_estado = ESPERA;
        // A play arriving on the last window cycle beats the timeout.
        if (jogada) proximo_estado = REGISTRA;
`ifdef JOGO_TIMEOUT_EN
        else if (expirou) proximo_estado = FIM_TIMEOUT;
`endif
      end
      REGISTRA: begin
        db_estado      = 4'h4;
        registra       = 1'b1;
        proximo_estado = COMPARACAO;
      end
      COMPARACAO: begin
        db_estado = 4'h5;
        if (!igual)             proximo_estado = FIM_ERRO;
        else if (!fim_endereco) proximo_estado = PROXIMO;
        else if (!fim_rodada)   proximo_estado = PROXIMA_RODADA;
        else                    proximo_estado = FIM_ACERTO;
      end
      PROXIMO: begin
        db_estado      = 4'h6;
        conta_endereco = 1'b1;
        proximo_estado = ESPERA;
      end
      PROXIMA_RODADA: begin
        db_estado      = 4'h7;
        conta_rodada   = 1'b1;
        proximo_estado = INICIA_RODADA;
      end
      FIM_ACERTO: begin
        db_estado      = 4'hA;
        acertou        = 1'b1;
        pronto         = 1'b1;
        proximo_estado = iniciar ? PREPARACAO : FIM_ACERTO;
      end
      FIM_ERRO: begin
        db_estado      = 4'hE;
        errou          = 1'b1;
        pronto         = 1'b1;
        proximo_estado = iniciar ? PREPARACAO : FIM_ERRO;
      end
`ifdef JOGO_TIMEOUT_EN
      FIM_TIMEOUT: begin
        db_estado      = 4'hD;
        timeout        = 1'b1;
        pronto         = 1'b1;
        proximo_estado = iniciar ? PREPARACAO : FIM_TIMEOUT;
      end
`endif
      default: begin
        db_estado      = 4'hF;
        proximo_estado = INICIAL;
      end
    endcase
  end

endmodule

// File: tb/tb_jogo_rodadas_unidade_controle.sv
// Self-checking bench for the round-based game control unit.
// A small datapath model (address/round counters) answers fim_endereco and
// fim_rodada; each scenario queues stimulus and the expected state code, and
// all Moore outputs are checked against the code popped from the scoreboard.
module tb_jogo_rodadas_unidade_controle;

  localparam int unsigned TIMEOUT = 10;
`ifdef JOGO_TIMEOUT_EN
  localparam logic [3:0] EXP_TO = 4'hD;
  localparam logic       TO_ON  = 1'b1;
`else
  localparam logic [3:0] EXP_TO = 4'h3;
  localparam logic       TO_ON  = 1'b0;
`endif

  logic       clock, reset, iniciar, jogada, igual, fim_endereco, fim_rodada;
  logic       zera_endereco, conta_endereco, zera_rodada, conta_rodada;
  logic       zera_registro, registra, acertou, errou, timeout, pronto, vez_jogador;
  logic [3:0] db_estado;

  jogo_rodadas_unidade_controle #(.TIMEOUT_CICLOS(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual),
    .fim_endereco(fim_endereco), .fim_rodada(fim_rodada),
    .zera_endereco(zera_endereco), .conta_endereco(conta_endereco),
    .zera_rodada(zera_rodada), .conta_rodada(conta_rodada),
    .zera_registro(zera_registro), .registra(registra), .acertou(acertou),
    .errou(errou), .timeout(timeout), .pronto(pronto), .vez_jogador(vez_jogador),
    .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Datapath model: address and round counters driven by the DUT strobes.
  int addr, rnd;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      addr <= 0;
      rnd  <= 0;
    end else begin
      if (zera_endereco)       addr <= 0;
      else if (conta_endereco) addr <= addr + 1;
      if (zera_rodada)         rnd <= 0;
      else if (conta_rodada)   rnd <= rnd + 1;
    end
  end
  assign fim_endereco = (addr == rnd);
  assign fim_rodada   = (rnd == 2);

  // Pulse counters sampled away from the active edge.
  int n_cr, n_ce, n_to;
  initial begin n_cr = 0; n_ce = 0; n_to = 0; end
  always @(negedge clock) begin
    if (conta_rodada)   n_cr++;
    if (conta_endereco) n_ce++;
    if (timeout)        n_to++;
  end

  logic [14:0] outs;
  assign outs = {zera_endereco, conta_endereco, zera_rodada, conta_rodada, zera_registro,
                 registra, acertou, errou, timeout, pronto, vez_jogador, db_estado};

  // Expected Moore outputs for a given state code.
  function automatic logic [14:0] saida_esperada(input logic [3:0] c);
    logic ze, ce, zr, cr, zg, rg, ac, er, to, pr, vz;
    {ze, ce, zr, cr, zg, rg, ac, er, to, pr, vz} = '0;
    case (c)
      4'h0, 4'h1: begin ze = 1; zr = 1; zg = 1; end
      4'h2: ze = 1;
      4'h3: vz = 1;
      4'h4: rg = 1;
      4'h6: ce = 1;
      4'h7: cr = 1;
      4'hA: begin ac = 1; pr = 1; end
      4'hE: begin er = 1; pr = 1; end
      4'hD: begin to = 1; pr = 1; end
      default: ;
    endcase
    return {ze, ce, zr, cr, zg, rg, ac, er, to, pr, vz, c};
  endfunction

  typedef struct packed {
    logic       ini;
    logic       jog;
    logic       ig;
    logic [3:0] code;
  } stim_t;

  stim_t      stim_q[$];
  logic [3:0] exp_q[$];
  int total, bad;

  task automatic add(input logic ini, input logic jog, input logic ig, input logic [3:0] code);
    stim_t s;
    s.ini = ini; s.jog = jog; s.ig = ig; s.code = code;
    stim_q.push_back(s);
  endtask

  task automatic add_idle(input int n, input logic [3:0] code);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b1, code);
  endtask

  task automatic add_start();
    add(1'b1, 1'b0, 1'b1, 4'h1);
    add(1'b0, 1'b0, 1'b1, 4'h2);
    add(1'b0, 1'b0, 1'b1, 4'h3);
  endtask

  // One play from espera: registra, comparacao, then the decided state.
  task automatic add_play(input logic ig, input logic [3:0] after);
    add(1'b0, 1'b1, ig, 4'h4);
    add(1'b0, 1'b0, ig, 4'h5);
    add(1'b0, 1'b0, ig, after);
    if (after == 4'h6) add(1'b0, 1'b0, 1'b1, 4'h3);
    if (after == 4'h7) begin
      add(1'b0, 1'b0, 1'b1, 4'h2);
      add(1'b0, 1'b0, 1'b1, 4'h3);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; iniciar = 1'b0; jogada = 1'b0; igual = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    stim_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    stim_t s;
    logic [3:0] e;
    @(negedge clock);
    total++;
    if (outs !== saida_esperada(4'h0)) begin
      bad++; $display("FAIL reset_state got=%h want=%h", outs, saida_esperada(4'h0));
    end
    reset = 1'b0;
    add_idle(3, 4'h0);
    add_start();
    add_play(1'b1, 4'h7);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      iniciar = s.ini; jogada = s.jog; igual = s.ig; exp_q.push_back(s.code);
      @(negedge clock);
      e = exp_q.pop_front(); total++;
      if (outs !== saida_esperada(e)) begin
        bad++; $display("FAIL reset_walk got=%h want=%h", outs, saida_esperada(e));
      end
    end
    // Asynchronous reset while waiting for the first play of round 1.
    #2 reset = 1'b1;
    #1 total++;
    if (outs !== saida_esperada(4'h0)) begin
      bad++; $display("FAIL reset_midgame got=%h want=%h", outs, saida_esperada(4'h0));
    end
    @(negedge clock);
    reset = 1'b0;
    add_idle(3, 4'h0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      iniciar = s.ini; jogada = s.jog; igual = s.ig; exp_q.push_back(s.code);
      @(negedge clock);
      e = exp_q.pop_front(); total++;
      if (outs !== saida_esperada(e)) begin
        bad++; $display("FAIL reset_release got=%h want=%h", outs, saida_esperada(e));
      end
    end
  endtask

  task automatic test_full_win();
    stim_t s;
    logic [3:0] e;
    int cr0, ce0;
    do_reset();
    cr0 = n_cr; ce0 = n_ce;
    add_start();
    add_play(1'b1, 4'h7);
    add_play(1'b1, 4'h6); add_play(1'b1, 4'h7);
    add_play(1'b1, 4'h6); add_play(1'b1, 4'h6); add_play(1'b1, 4'hA);
    add_idle(2, 4'hA);
    add_start();
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      iniciar = s.ini; jogada = s.jog; igual = s.ig; exp_q.push_back(s.code);
      @(negedge clock);
      e = exp_q.pop_front(); total++;
      if (outs !== saida_esperada(e)) begin
        bad++; $display("FAIL win_walk got=%h want=%h", outs, saida_esperada(e));
      end
    end
    total++;
    if (n_cr - cr0 !== 2) begin
      bad++; $display("FAIL win_conta_rodada got=%0d want=2", n_cr - cr0);
    end
    total++;
    if (n_ce - ce0 !== 3) begin
      bad++; $display("FAIL win_conta_endereco got=%0d want=3", n_ce - ce0);
    end
  endtask

  task automatic test_mismatch();
    stim_t s;
    logic [3:0] e;
    do_reset();
    add_start();
    add_play(1'b1, 4'h7);
    add_play(1'b1, 4'h6);
    add_play(1'b0, 4'hE);
    add_idle(2, 4'hE);
    add(1'b1, 1'b0, 1'b1, 4'h1);
    add(1'b0, 1'b0, 1'b1, 4'h2);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      iniciar = s.ini; jogada = s.jog; igual = s.ig; exp_q.push_back(s.code);
      @(negedge clock);
      e = exp_q.pop_front(); total++;
      if (outs !== saida_esperada(e)) begin
        bad++; $display("FAIL mismatch_walk got=%h want=%h", outs, saida_esperada(e));
      end
    end
  endtask

  task automatic test_timeout();
    stim_t s;
    logic [3:0] e;
    do_reset();
    add_start();
`ifdef JOGO_TIMEOUT_EN
    add_idle(9, 4'h3);
    add_idle(2, 4'hD);
`else
    add_idle(99, 4'h3);
`endif
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      iniciar = s.ini; jogada = s.jog; igual = s.ig; exp_q.push_back(s.code);
      @(negedge clock);
      e = exp_q.pop_front(); total++;
      if (outs !== saida_esperada(e)) begin
        bad++; $display("FAIL timeout_walk got=%h want=%h", outs, saida_esperada(e));
      end
    end
    total++;
    if (timeout !== TO_ON || pronto !== TO_ON) begin
      bad++; $display("FAIL timeout_flag got=%b/%b want=%b", timeout, pronto, TO_ON);
    end
  endtask

  task automatic test_race();
    stim_t s;
    logic [3:0] e;
    int to0;
    do_reset();
    to0 = n_to;
    add_start();
    add_idle(9, 4'h3);
    add_play(1'b1, 4'h7);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      iniciar = s.ini; jogada = s.jog; igual = s.ig; exp_q.push_back(s.code);
      @(negedge clock);
      e = exp_q.pop_front(); total++;
      if (outs !== saida_esperada(e)) begin
        bad++; $display("FAIL race_walk got=%h want=%h", outs, saida_esperada(e));
      end
    end
    total++;
    if (n_to - to0 !== 0) begin
      bad++; $display("FAIL race_no_timeout got=%0d want=0", n_to - to0);
    end
  endtask

  task automatic test_window_restart();
    stim_t s;
    logic [3:0] e;
    int to0;
    do_reset();
    to0 = n_to;
    add_start();
    add_play(1'b1, 4'h7);
    add_idle(7, 4'h3);
    add_play(1'b1, 4'h6);
    add_idle(9, 4'h3);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      iniciar = s.ini; jogada = s.jog; igual = s.ig; exp_q.push_back(s.code);
      @(negedge clock);
      e = exp_q.pop_front(); total++;
      if (outs !== saida_esperada(e)) begin
        bad++; $display("FAIL window_walk got=%h want=%h", outs, saida_esperada(e));
      end
    end
    total++;
    if (n_to - to0 !== 0) begin
      bad++; $display("FAIL window_early_timeout got=%0d want=0", n_to - to0);
    end
    add_idle(1, EXP_TO);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      iniciar = s.ini; jogada = s.jog; igual = s.ig; exp_q.push_back(s.code);
      @(negedge clock);
      e = exp_q.pop_front(); total++;
      if (outs !== saida_esperada(e)) begin
        bad++; $display("FAIL window_expire got=%h want=%h", outs, saida_esperada(e));
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; iniciar = 1'b0; jogada = 1'b0; igual = 1'b1;
    test_reset();
    test_full_win();
    test_mismatch();
    test_timeout();
    test_race();
    test_window_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jogo_rodadas_unidade_controle.md
Name: jogo_rodadas_unidade_controle

Overview:
- Moore FSM sequencing the round-based memory-game datapath: address counter, round counter, play register and comparator.
- Each round N requires the player to repeat memory positions 0..N. The game ends on the first mismatch, on completion of the last round, or on a per-play timeout.
- Sits beside the datapath in the game top level. It replaces the single-pass control unit.

Parameters:
- TIMEOUT_CICLOS, default 5000: clock cycles allowed in espera before a timeout; legal range ≥2.
- TIMER_W, default $clog2(TIMEOUT_CICLOS): internal timer width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; forces inicial.
- iniciar  input  1  start / restart request; level sampled.
- jogada  input  1  one-cycle pulse from datapath edge detector: play available.
- igual  input  1  registered play equals memory word at current address.
- fim_endereco  input  1  address counter equals round counter.
- fim_rodada  input  1  round counter at last round.
- zera_endereco  output  1  synchronous clear, address counter.
- conta_endereco  output  1  increment, address counter.
- zera_rodada  output  1  synchronous clear, round counter.
- conta_rodada  output  1  increment, round counter.
- zera_registro  output  1  clear play register.
- registra  output  1  load play register.
- acertou  output  1  game won.
- errou  output  1  game lost by mismatch.
- timeout  output  1  game lost by timeout.
- pronto  output  1  game finished (any end state).
- vez_jogador  output  1  waiting for a play (espera).
- db_estado  output  4  state code for 7-segment debug.

Behaviour:
- All outputs are Moore, decoded only from the registered state. There is no input-to-output combinational path.
- Reset: state = inicial immediately. Outputs: zera_endereco=1, zera_rodada=1, zera_registro=1, all others 0, db_estado=0. Internal timer = 0.
- States and encodings:
  - inicial 0: iniciar → preparacao; else stay.
  - preparacao 1: zera_endereco, zera_rodada, zera_registro asserted → inicia_rodada.
  - inicia_rodada 2: zera_endereco asserted → espera.
  - espera 3: vez_jogador asserted. jogada → registra. Else if timer == TIMEOUT_CICLOS-1 → fim_timeout. Else stay.
  - registra 4: registra asserted → comparacao.
  - comparacao 5:
    - !igual → fim_erro.
    - igual & !fim_endereco → proximo.
    - igual & fim_endereco & !fim_rodada → proxima_rodada.
    - igual & fim_endereco & fim_rodada → fim_acerto.
  - proximo 6: conta_endereco asserted → espera.
  - proxima_rodada 7: conta_rodada asserted → inicia_rodada.
  - fim_acerto A: acertou=1, pronto=1.
  - fim_erro E: errou=1, pronto=1.
  - fim_timeout D: timeout=1, pronto=1.
  - In all three end states: iniciar → preparacao; else stay.
- Unused encodings → inicial next cycle; db_estado=F while in them.
- Timer:
  - Cleared to 0 in every state other than espera.
  - Increments by 1 each cycle spent in espera.
  - With no jogada, the FSM enters fim_timeout exactly TIMEOUT_CICLOS cycles after entering espera.
  - Each new play (via proximo) restarts the full window.
- Simultaneous events: jogada in the same cycle the timer reaches its limit → registra. jogada wins; no timeout.
- iniciar is ignored in all states except inicial and the end states.
- jogada is ignored outside espera.
- Reset mid-game: immediate return to inicial, timer cleared, no end flag asserted.
- Latency:
  - iniciar to vez_jogador = 3 cycles (preparacao, inicia_rodada, espera).
  - jogada to end flag or vez_jogador = 3 cycles (registra, comparacao, next state).

Optional Feature:
- Macro JOGO_TIMEOUT_EN.
- Defined: timer, fim_timeout state and timeout output behave as above.
- Undefined:
  - No timer logic is synthesized; espera waits indefinitely for jogada.
  - timeout is tied to 0.
  - Encoding D is unused and falls under the default rule (→ inicial, db_estado=F).

Test Plan:
- Reset mid-game: TIMEOUT_CICLOS=10; reach espera in round 1, assert reset → same cycle db_estado=0, zera_endereco=1, zera_rodada=1, vez_jogador=0. After release with iniciar=0, db_estado stays 0.
- Full win: fim_rodada=1 from round 2. Bench plays correct sequences for rounds 0, 1, 2 (1+2+3 plays, igual=1). Expect:
  - db_estado walk 0,1,2,3,4,5,7,2,3,…
  - conta_rodada pulses twice, conta_endereco pulses three times.
  - Final db_estado=A, acertou=1, pronto=1.
- Mismatch: round 1, second play with igual=0 → comparacao then db_estado=E, errou=1, pronto=1, acertou=0. Then iniciar=1 → preparacao (1), zera_rodada=1.
- Timeout: TIMEOUT_CICLOS=10; enter espera, hold jogada=0 → vez_jogador=1 for 10 cycles, then db_estado=D, timeout=1, pronto=1. With JOGO_TIMEOUT_EN undefined, the same stimulus stays in espera for 100 cycles with timeout=0.
- Race: jogada pulse on the 10th espera cycle (timer=9) → next state registra (4), timeout never asserted.
- Window restart: correct play at espera cycle 8 → proximo → espera, then 9 idle cycles without timeout. Timeout occurs on the 10th idle cycle.
